// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: Dallas/Maxim CRC-8 constants, the transmitter state
// encoding and a single-bit CRC step that the receive-side checker also uses.
package one_wire_pkg;

   localparam logic [7:0]  CRC8_POLY         = 8'h8C;
   localparam int unsigned UID_WIDTH_DEFAULT = 56;
   localparam int unsigned CRC_BITS          = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_CRC  = 2'd2,
      ST_DONE = 2'd3
   } tx_state_t;

   // Reflected CRC-8 (x^8 + x^5 + x^4 + 1), advanced by one serial bit, LSB first.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic data_bit);
      logic fb;
      fb = crc[0] ^ data_bit;
      return (crc >> 1) ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/one_wire_crc_tx_if.sv
// Bit-level valid/ready stream from the serializer to the 1-Wire timeslot engine.
interface one_wire_crc_tx_if;

   logic bit_valid;
   logic bit_data;
   logic bit_ready;

   modport master (
      output bit_valid,
      output bit_data,
      input  bit_ready
   );

   modport slave (
      input  bit_valid,
      input  bit_data,
      output bit_ready
   );

endinterface

// File: rtl/one_wire_crc_tx.sv
// Serializes a ROM/UID payload LSB first, then appends its Dallas CRC-8 byte,
// handing one bit at a time to a timeslot engine over a valid/ready stream.
module one_wire_crc_tx
   import one_wire_pkg::*;
#(
   parameter int unsigned UID_SERIAL_DATA_WIDTH = UID_WIDTH_DEFAULT,
   parameter logic [7:0]  CRC_INIT              = 8'h00
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [UID_SERIAL_DATA_WIDTH-1:0] payload,
   one_wire_crc_tx_if.master                bits,
   output logic                             busy,
   output logic [7:0]                       crc_out,
   output logic                             done
);

   localparam int unsigned      CNT_W    = $clog2(UID_SERIAL_DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(UID_SERIAL_DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(CRC_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   tx_state_t                      state;
   tx_state_t                      state_next;
   logic [UID_SERIAL_DATA_WIDTH-1:0] shift_reg;
   logic [7:0]                     crc;
   logic [7:0]                     crc_shift;
   logic [7:0]                     crc_stepped;
   logic [CNT_W-1:0]               count;
   logic                           last_bit;
   logic                           xfer;
   logic                           valid_int;
   logic                           data_int;

   assign xfer        = valid_int & bits.bit_ready;
   assign last_bit    = (count == CNT_ONE);
   assign crc_stepped = crc8_step(crc, shift_reg[0]);

   assign bits.bit_valid = valid_int;
   assign bits.bit_data  = data_int;
   assign crc_out        = crc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The offered bit comes straight from a register, so it cannot move while stalled.
   always_comb begin
      state_next = state;
      valid_int  = 1'b0;
      data_int   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            valid_int = 1'b1;
            data_int  = shift_reg[0];
            if (xfer && last_bit) begin
               state_next = ST_CRC;
            end
         end
         ST_CRC: begin
            valid_int = 1'b1;
            data_int  = crc_shift[0];
            if (xfer && last_bit) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The final CRC is copied into crc_shift on the last payload transfer so the
   // CRC byte follows with no bubble while crc itself stays frozen for crc_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         crc       <= CRC_INIT;
         crc_shift <= 8'h00;
         count     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shift_reg <= payload;
                  crc       <= CRC_INIT;
                  count     <= CNT_DATA;
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  crc       <= crc_stepped;
                  shift_reg <= shift_reg >> 1;
                  if (last_bit) begin
                     count     <= CNT_CRC;
                     crc_shift <= crc_stepped;
                  end else begin
                     count <= count - CNT_ONE;
                  end
               end
            end
            ST_CRC: begin
               if (xfer) begin
                  crc_shift <= crc_shift >> 1;
                  count     <= count - CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/one_wire_crc_tx.md
ONE_WIRE_CRC_TX -- requirements
Module: one_wire_crc_tx

Interface
REQ-001 Parameter: UID_SERIAL_DATA_WIDTH, default 56, payload bits serialized before the CRC byte.
REQ-002 Parameter: CRC_INIT, default 8'h00, CRC register value loaded at start.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: start  in  1  one-cycle request to transmit payload; sampled only in IDLE.
REQ-006 Port: payload  in  UID_SERIAL_DATA_WIDTH  data to send, LSB first; captured on accepted start.
REQ-007 Port: bit_valid  out  1  bit_data holds a bit offered to the timeslot engine.
REQ-008 Port: bit_data  out  1  current serial bit.
REQ-009 Port: bit_ready  in  1  timeslot engine accepts bit; transfer = bit_valid & bit_ready.
REQ-010 Port: busy  out  1  high in any state other than IDLE.
REQ-011 Port: crc_out  out  8  running/final Dallas CRC-8 of the payload.
REQ-012 Port: done  out  1  one-cycle pulse after the final CRC bit transfers.

Function
REQ-013 States SHALL be IDLE, DATA, CRC, DONE; encoding 2 bits.
REQ-014 IDLE: start=1 at edge N SHALL capture payload into a shift register, load crc to CRC_INIT, load bit counter to UID_SERIAL_DATA_WIDTH, enter DATA; bit_valid=1 with payload[0] from cycle N+1.
REQ-015 start while busy SHALL be ignored; no queuing.
REQ-016 bit_valid SHALL stay high and bit_data stable until a transfer; no bit is dropped or repeated.
REQ-017 On each DATA transfer: fb = crc[0] ^ bit_data; crc <= (crc >> 1) ^ (fb ? 8'h8C : 8'h00); payload shifts right; counter decrements.
REQ-018 Transfer of the last payload bit (counter==1) SHALL enter CRC, counter loaded to 8; next offered bit is crc[0] of the final CRC, with no bubble cycle (bit_valid stays high).
REQ-019 In CRC, bits SHALL be sent LSB first from a shifted copy; crc_out SHALL stay frozen at the final value.
REQ-020 Transfer of the 8th CRC bit SHALL enter DONE, drop bit_valid next cycle; DONE asserts done for exactly one cycle, then IDLE.
REQ-021 Total transfers per frame SHALL be UID_SERIAL_DATA_WIDTH + 8 (64 default).
REQ-022 crc_out SHALL hold the final CRC from DONE until the next accepted start.
REQ-023 bit_ready while bit_valid=0 SHALL have no effect.
REQ-024 Counter width SHALL be $clog2(UID_SERIAL_DATA_WIDTH+1); no wrap-around permitted.

Reset
REQ-025 rst=1 at any edge, including mid-frame, SHALL force IDLE next cycle: bit_valid=0, bit_data=0, busy=0, done=0, crc_out=CRC_INIT, counter=0; partial frame discarded.
REQ-026 rst SHALL take priority over start and bit_ready in the same cycle.

Structure
REQ-027 Shared package one_wire_pkg SHALL hold: CRC8 reflected polynomial 8'h8C, default UID width 56, state enum, and a crc8_step(crc, bit) function reused by the receive-side checker.
REQ-028 No sub-module; single module with one FSM and datapath registers.

Verification
REQ-029 payload=56'h00000001B81C02, bit_ready tied 1 -> 64 transfers, last 8 bits = 8'hA2 LSB first, crc_out=8'hA2, done one cycle after transfer 64.
REQ-030 payload=0, bit_ready tied 1 -> 64 zero bits, crc_out=8'h00, busy high exactly 65 cycles.
REQ-031 AN27 payload, bit_ready random 30% duty -> identical bit sequence, bit_data never changes while bit_valid & ~bit_ready.
REQ-032 Second start pulse mid-frame -> ignored; frame completes with original payload and CRC 8'hA2.
REQ-033 rst asserted after 20 transfers -> next cycle bit_valid=0, busy=0, crc_out=8'h00; subsequent start sends full fresh 64-bit frame.
REQ-034 start and rst same cycle -> remains IDLE, busy=0.
